// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The optional leading-zero suppression is enabled with SEG7_LEADING_ZERO_BLANK_EN.
package seg7_pkg;
   typedef enum logic {GUARD, DRIVE} scan_state_t;

   localparam logic [7:0] SEG_OFF    = 8'hFF;
   localparam logic [3:0] ANODE_OFF  = 4'hF;
   localparam int         NUM_DIGITS = 4;

   // One complete display image: four hex nibbles, decimal points, blanks.
   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic [3:0]  blank;
   } image_t;
endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low a..g glyph (bit 0 = a, bit 6 = g).
module seg7_hex_decode (
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);
   always_comb begin
      glyph = 7'h7F;
      case (nibble)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         4'hF: glyph = 7'h0E;
         default: glyph = 7'h7F;
      endcase
   end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with double-buffered image and
// per-slot dark guard. Define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        input_clock,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   output logic        ready,
   output logic        frame_done,
   output logic [7:0]  out,
   output logic [3:0]  anode
);
   localparam int              PW         = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0]   PHASE_LAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] phase_reg, phase_next;
   logic [1:0]    slot_reg, slot_next;
   scan_state_t   state_reg, state_next;
   image_t        pend_reg, pend_next, act_reg, act_next;
   logic          pend_valid_reg, pend_valid_next;
   logic [7:0]    out_reg, out_next;
   logic [3:0]    anode_reg, anode_next;

   logic          phase_last, frame_end, commit, capture;
   logic [3:0]    eff_blank;
   logic [3:0]    cur_nibble;
   logic [6:0]    cur_glyph;

   assign phase_last = (phase_reg == PHASE_LAST);
   assign frame_end  = phase_last && (slot_reg == 2'd3);
   assign commit     = frame_end && pend_valid_reg;
   assign capture    = load && !pend_valid_reg;

   // Outputs are decoded from next-cycle values so they land on the same edge
   // as the phase/slot/image they belong to.
   assign act_next   = commit ? pend_reg : act_reg;
   assign cur_nibble = act_next.digits[{slot_next, 2'b00} +: 4];

   seg7_hex_decode u_decode (
      .nibble (cur_nibble),
      .glyph  (cur_glyph)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [3:0] zero_or_blank;
   logic [3:0] above_ok;
   logic [3:0] lead_zero;
   assign above_ok[NUM_DIGITS-1] = 1'b1;
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      assign zero_or_blank[gi] = (act_next.digits[4*gi +: 4] == 4'h0) || act_next.blank[gi];
      if (gi < NUM_DIGITS - 1) begin : g_chain
         assign above_ok[gi] = above_ok[gi+1] && zero_or_blank[gi+1];
      end
      if (gi == 0) begin : g_units
         assign lead_zero[gi] = 1'b0;
      end else begin : g_upper
         assign lead_zero[gi] = (act_next.digits[4*gi +: 4] == 4'h0) && above_ok[gi];
      end
   end
   assign eff_blank = act_next.blank | lead_zero;
`else
   assign eff_blank = act_next.blank;
`endif

   always_comb begin
      phase_next      = phase_last ? '0 : phase_reg + 1'b1;
      slot_next       = phase_last ? slot_reg + 2'd1 : slot_reg;
      pend_next       = capture ? image_t'{digits_in, dp_in, blank_in} : pend_reg;
      pend_valid_next = capture || (pend_valid_reg && !commit);
      state_next      = state_reg;
      out_next        = SEG_OFF;
      anode_next      = ANODE_OFF;

      case (state_reg)
         GUARD: if (int'(phase_next) >= BLANK_CYCLES) state_next = DRIVE;
         DRIVE: if (phase_last && BLANK_CYCLES > 0) state_next = GUARD;
         default: state_next = GUARD;
      endcase

      if (state_next == DRIVE && !eff_blank[slot_next]) begin
         anode_next = ~(4'b0001 << slot_next);
         out_next   = {~act_next.dp[slot_next], cur_glyph};
      end
   end

   always_ff @(posedge input_clock or posedge reset) begin
      if (reset) begin
         phase_reg      <= '0;
         slot_reg       <= 2'd0;
         state_reg      <= GUARD;
         pend_reg       <= '0;
         pend_valid_reg <= 1'b0;
         act_reg        <= image_t'{16'h0000, 4'h0, 4'hF};
         out_reg        <= SEG_OFF;
         anode_reg      <= ANODE_OFF;
      end else begin
         phase_reg      <= phase_next;
         slot_reg       <= slot_next;
         state_reg      <= state_next;
         pend_reg       <= pend_next;
         pend_valid_reg <= pend_valid_next;
         act_reg        <= act_next;
         out_reg        <= out_next;
         anode_reg      <= anode_next;
      end
   end

   assign ready      = !pend_valid_reg;
   assign frame_done = frame_end;
   assign out        = out_reg;
   assign anode      = anode_reg;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_seg7_scan_ctrl;
   localparam int DIV   = 8;
   localparam int BLK   = 2;
   localparam int FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic        ready, frame_done;
   logic [7:0]  seg_out;
   logic [3:0]  anode;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
      .input_clock (clk),
      .reset       (rst),
      .load        (load),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .ready       (ready),
      .frame_done  (frame_done),
      .out         (seg_out),
      .anode       (anode)
   );

   typedef struct packed {
      logic [7:0] out;
      logic [3:0] anode;
      logic       ready;
      logic       fd;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;
   bit   started = 0;

   logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference model: cycle count since reset, pending and active images.
   int          m_t;
   bit          m_pv;
   logic [15:0] m_pd, m_ad;
   logic [3:0]  m_pdp, m_adp, m_pbl, m_abl;

   function automatic bit digit_dark(int sl);
      bit d = m_abl[sl];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (sl > 0 && m_ad[sl*4 +: 4] == 4'h0) begin
         bit all_hi = 1;
         for (int j = sl + 1; j < 4; j++)
            if (!(m_ad[j*4 +: 4] == 4'h0 || m_abl[j])) all_hi = 0;
         if (all_hi) d = 1;
      end
`endif
      return d;
   endfunction

   function automatic exp_t predict();
      exp_t       e;
      int         ph = m_t % DIV;
      int         sl = (m_t / DIV) % 4;
      logic [7:0] g;
      e.out   = 8'hFF;
      e.anode = 4'hF;
      e.ready = !m_pv;
      e.fd    = (m_t % FRAME) == FRAME - 1;
      if (ph >= BLK && !digit_dark(sl)) begin
         e.anode = 4'hF ^ (4'h1 << sl);
         g       = glyph_tab[m_ad[sl*4 +: 4]];
         e.out   = {~m_adp[sl], g[6:0]};
      end
      return e;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_t = 0; m_pv = 0;
         m_ad = '0; m_adp = '0; m_abl = 4'hF;
         q.delete();
         q.push_back(predict());
      end else begin
         if ((m_t % FRAME) == FRAME - 1 && m_pv) begin
            m_ad = m_pd; m_adp = m_pdp; m_abl = m_pbl; m_pv = 0;
         end else if (load && !m_pv) begin
            m_pd = digits_in; m_pdp = dp_in; m_pbl = blank_in; m_pv = 1;
         end
         m_t++;
         q.push_back(predict());
      end
   end

   always @(negedge clk) begin
      if (started) begin
         exp_t e;
         checks++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
         end else begin
            e = q.pop_front();
            if ({seg_out, anode, ready, frame_done} !== e) begin
               fails++;
               $display("FAIL cycle t=%0t got out=%h anode=%h ready=%b fd=%b expected out=%h anode=%h ready=%b fd=%b",
                        $time, seg_out, anode, ready, frame_done, e.out, e.anode, e.ready, e.fd);
            end
         end
      end
   end

   task automatic cycles(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(logic [15:0] d, logic [3:0] dp, logic [3:0] bl);
      load = 1'b1; digits_in = d; dp_in = dp; blank_in = bl;
      cycles(1);
      load = 1'b0;
      digits_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
   endtask

   task automatic wait_frame_pos(int pos);
      int n = 0;
      while ((m_t % FRAME) != pos && n < 2 * FRAME) begin
         cycles(1);
         n++;
      end
      if ((m_t % FRAME) != pos) begin
         checks++;
         fails++;
         $display("FAIL wait_frame_pos timeout pos=%0d at=%0d", pos, m_t % FRAME);
      end
   endtask

   initial begin
      #2;
      rst = 1'b1;
      started = 1;
      cycles(2);
      rst = 1'b0;

      cycles(2 * FRAME);                                   // idle: dark, ready
      do_load(16'hF810, 4'h0, 4'h0);
      cycles(2 * FRAME);
      do_load(16'h1111, 4'h0, 4'h0);                       // second load ignored
      do_load(16'h2222, 4'h0, 4'h0);
      cycles(2 * FRAME);
      do_load(16'h0000, 4'b0001, 4'b0100);
      cycles(2 * FRAME);
      do_load(16'h0012, 4'h0, 4'h0);
      cycles(2 * FRAME);
      do_load(16'h0000, 4'h0, 4'h0);
      cycles(2 * FRAME);

      // load coinciding with frame end while pending is empty
      wait_frame_pos(FRAME - 1);
      do_load(16'h9A5C, 4'b1010, 4'h0);
      cycles(2 * FRAME);

      // reset mid-DRIVE of slot 2 with an image pending
      wait_frame_pos(0);
      do_load(16'h4567, 4'hF, 4'h0);
      wait_frame_pos(2 * DIV + 4);
      rst = 1'b1;
      #1;
      checks++;
      if (seg_out !== 8'hFF || anode !== 4'hF) begin
         fails++;
         $display("FAIL async_reset got out=%h anode=%h expected out=ff anode=f", seg_out, anode);
      end
      cycles(1);
      rst = 1'b0;
      cycles(2 * FRAME);

      for (int i = 0; i < 40; i++) begin
         cycles($urandom_range(0, 40));
         do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)));
      end
      cycles(2 * FRAME);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
